// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter: round-robin (or fixed-priority with ARB_FIXED_PRIO_EN) write-port arbiter over a 2^AW x DW flop bank with burst locking and a combinational read port
module dff_bank_arbiter #(
  parameter int NREQ = 4,
  parameter int AW = 3,
  parameter int DW = 8,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   lock,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  input  logic [AW-1:0]     rd_addr,
  output logic [DW-1:0]     rd_data,
  output logic              busy
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nx;
  logic [DW-1:0] bank [2**AW];
  logic [IW-1:0] own, own_nx, start, win;
  logic [NREQ-1:0] cand, gnt_nx;
  logic [CW-1:0] burst_cnt, cnt_nx;
  logic found, wr, stay, arb;
`ifdef ARB_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [IW-1:0] ptr, own_inc;
  assign own_inc = own == IW'(NREQ - 1) ? '0 : own + 1'b1;
  assign start = state == GRANT ? own_inc : ptr;
`endif
  assign cand = state == GRANT ? req & ~(NREQ'(1) << own) : req;
  assign busy = state == GRANT;
  assign rd_data = bank[rd_addr];
  always_comb begin
    logic [IW:0] sum;
    logic [IW-1:0] idx;
    found = 1'b0;
    win = '0;
    sum = '0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, start} + (IW+1)'(k);
      idx = sum >= (IW+1)'(NREQ) ? IW'(sum - (IW+1)'(NREQ)) : IW'(sum);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  always_comb begin
    wr = state == GRANT && req[own];
    stay = wr && lock[own] && int'(burst_cnt) + 1 < MAX_BURST;
    arb = state == IDLE || !stay;
    state_nx = arb ? (found ? GRANT : IDLE) : state;
    gnt_nx = arb ? (found ? NREQ'(1) << win : '0) : gnt;
    own_nx = arb ? win : own;
    cnt_nx = stay ? burst_cnt + 1'b1 : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      ack <= '0;
      own <= '0;
      burst_cnt <= '0;
      for (int i = 0; i < 2**AW; i++) bank[i] <= '0;
`ifndef ARB_FIXED_PRIO_EN
      ptr <= '0;
`endif
    end else begin
      state <= state_nx;
      gnt <= gnt_nx;
      own <= own_nx;
      burst_cnt <= cnt_nx;
      ack <= wr ? NREQ'(1) << own : '0;
      if (wr) bank[addr[int'(own)*AW +: AW]] <= wdata[int'(own)*DW +: DW];
`ifndef ARB_FIXED_PRIO_EN
      if (state == GRANT && !stay) ptr <= own_inc;
`endif
    end
  end
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb_dff_bank_arbiter: vector table, corner sequences and random traffic against a behavioural model
module tb_dff_bank_arbiter;
  localparam int N = 4, AW = 3, DW = 8, MB = 8;
  logic clk = 1'b0, rst;
  logic [N-1:0] req, lock, gnt, ack;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic busy;
  always #5 clk = ~clk;
  dff_bank_arbiter #(.NREQ(N), .AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .addr(addr), .wdata(wdata),
    .gnt(gnt), .ack(ack), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );
  int nvec = 0, nerr = 0;
  int m_own = -1, m_ptr = 0, m_cnt = 0;
  logic [DW-1:0] m_mem [2**AW];
  logic [N-1:0] m_ack = '0;
  typedef struct {
    logic r;
    logic [N-1:0] rq, lk;
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] d;
    logic [AW-1:0] ra;
    logic [N-1:0] eg, ea;
    logic eb;
    logic [DW-1:0] er;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(input logic r, input logic [N-1:0] rq, lk, input logic [N*AW-1:0] a,
                              input logic [N*DW-1:0] d, input logic [AW-1:0] ra,
                              input logic [N-1:0] eg, ea, input logic eb, input logic [DW-1:0] er);
    vec_t v;
    v.r = r; v.rq = rq; v.lk = lk; v.a = a; v.d = d; v.ra = ra;
    v.eg = eg; v.ea = ea; v.eb = eb; v.er = er;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask
  function automatic int pick(input logic [N-1:0] r, input int start, input int excl);
`ifdef ARB_FIXED_PRIO_EN
    start = 0;
`endif
    for (int k = 0; k < N; k++) begin
      int i;
      i = (start + k) % N;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction
  task automatic model_step(input logic r, input logic [N-1:0] rq, lk, input logic [N*AW-1:0] a,
                            input logic [N*DW-1:0] d);
    int o;
    if (r) begin
      m_own = -1; m_ptr = 0; m_cnt = 0; m_ack = '0;
      foreach (m_mem[i]) m_mem[i] = '0;
      return;
    end
    m_ack = '0;
    if (m_own < 0) begin
      m_own = pick(rq, m_ptr, -1);
      m_cnt = 0;
    end else begin
      o = m_own;
      if (rq[o]) begin
        m_mem[a[o*AW +: AW]] = d[o*DW +: DW];
        m_ack[o] = 1'b1;
        m_cnt++;
      end
      if (!(rq[o] && lk[o] && m_cnt < MB)) begin
        m_ptr = (o + 1) % N;
        m_own = pick(rq, m_ptr, o);
        m_cnt = 0;
      end
    end
  endtask
  task automatic apply(input logic r, input logic [N-1:0] rq, lk, input logic [N*AW-1:0] a,
                       input logic [N*DW-1:0] d, input logic [AW-1:0] ra);
    rst = r; req = rq; lock = lk; addr = a; wdata = d; rd_addr = ra;
    #1;
    if (!r) chk("rd_pre", rd_data, m_mem[ra]);
    model_step(r, rq, lk, a, d);
    @(posedge clk);
    #1;
    chk("gnt", gnt, m_own < 0 ? 0 : 1 << m_own);
    chk("ack", ack, m_ack);
    chk("busy", busy, m_own >= 0);
    chk("rd", rd_data, m_mem[ra]);
  endtask
  initial begin
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    for (int i = 2; i < 8; i++) tbl.push_back(mk(0, 0, 0, 0, 0, AW'(i), 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 0, 12'h140, 32'h00A5_0000, 5, 4'b0100, 0, 1, 8'h00));
    tbl.push_back(mk(0, 4'b0100, 0, 12'h140, 32'h00A5_0000, 5, 4'b0000, 4'b0100, 0, 8'hA5));
    tbl.push_back(mk(0, 0, 0, 0, 0, 5, 0, 0, 0, 8'hA5));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef ARB_FIXED_PRIO_EN
    tbl.push_back(mk(0, 4'b1010, 0, 12'h688, 32'h1312_1110, 1, 4'b0010, 4'b0000, 1, 8'h00));
    tbl.push_back(mk(0, 4'b1010, 0, 12'h688, 32'h1312_1110, 1, 4'b1000, 4'b0010, 1, 8'h11));
    tbl.push_back(mk(0, 4'b1010, 0, 12'h688, 32'h1312_1110, 1, 4'b0010, 4'b1000, 1, 8'h11));
    tbl.push_back(mk(0, 4'b1010, 0, 12'h688, 32'h1312_1110, 1, 4'b1000, 4'b0010, 1, 8'h11));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000, 0, 8'h11));
`else
    tbl.push_back(mk(0, 4'b1111, 0, 12'h688, 32'h1312_1110, 0, 4'b0001, 4'b0000, 1, 8'h00));
    tbl.push_back(mk(0, 4'b1111, 0, 12'h688, 32'h1312_1110, 0, 4'b0010, 4'b0001, 1, 8'h10));
    tbl.push_back(mk(0, 4'b1111, 0, 12'h688, 32'h1312_1110, 0, 4'b0100, 4'b0010, 1, 8'h10));
    tbl.push_back(mk(0, 4'b1111, 0, 12'h688, 32'h1312_1110, 0, 4'b1000, 4'b0100, 1, 8'h10));
    tbl.push_back(mk(0, 4'b1111, 0, 12'h688, 32'h1312_1110, 0, 4'b0001, 4'b1000, 1, 8'h10));
    tbl.push_back(mk(0, 4'b1111, 0, 12'h688, 32'h1312_1110, 0, 4'b0010, 4'b0001, 1, 8'h10));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 8'h10));
`endif
    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].rq, tbl[i].lk, tbl[i].a, tbl[i].d, tbl[i].ra);
      chk("t_gnt", gnt, tbl[i].eg);
      chk("t_ack", ack, tbl[i].ea);
      chk("t_busy", busy, tbl[i].eb);
      chk("t_rd", rd_data, tbl[i].er);
    end
    apply(1, 0, 0, 0, 0, 0);
    apply(0, 4'b1010, 4'b0010, 0, 0, 0);
    chk("b_gnt0", gnt, 4'b0010);
    for (int k = 0; k < 8; k++) begin
      apply(0, 4'b1010, 4'b0010, 12'(k) << 3, 32'(k + 1) << 8, 0);
      chk("b_ack", ack, 4'b0010);
      chk("b_gnt", gnt, k < 7 ? 4'b0010 : 4'b1000);
    end
    apply(0, 0, 0, 0, 0, 0);
    chk("b_rel_gnt", gnt, 0);
    chk("b_rel_ack", ack, 0);
    for (int k = 0; k < 8; k++) begin
      apply(0, 0, 0, 0, 0, AW'(k));
      chk("b_rd", rd_data, k + 1);
    end
    apply(0, 4'b0001, 0, 0, 32'hFF, 0);
    chk("d_gnt", gnt, 4'b0001);
    apply(0, 0, 0, 0, 32'hFF, 0);
    chk("d_gnt_rel", gnt, 0);
    chk("d_ack", ack, 0);
    chk("d_busy", busy, 0);
    chk("d_rd", rd_data, 8'h01);
    apply(0, 0, 0, 0, 0, 0);
    chk("d_ack2", ack, 0);
    apply(0, 4'b0010, 4'b0010, 0, 32'h0000_5500, 0);
    chk("r_gnt", gnt, 4'b0010);
    apply(0, 4'b0010, 4'b0010, 0, 32'h0000_5500, 0);
    chk("r_ack", ack, 4'b0010);
    chk("r_rd", rd_data, 8'h55);
    apply(1, 4'b0010, 4'b0010, 12'h008, 32'h0000_6600, 0);
    chk("r_gnt_rst", gnt, 0);
    chk("r_ack_rst", ack, 0);
    chk("r_busy_rst", busy, 0);
    for (int k = 0; k < 8; k++) begin
      apply(0, 0, 0, 0, 0, AW'(k));
      chk("r_clr", rd_data, 0);
    end
    for (int i = 0; i < 400; i++)
      apply($urandom_range(0, 49) == 0, N'($urandom), N'($urandom | $urandom), (N*AW)'($urandom),
            (N*DW)'($urandom), AW'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Owns a bank of 2^AW x DW D flip-flops and shares its single write port among NREQ requesters.
- Round-robin arbitration; each grant is one write, or a locked burst of up to MAX_BURST writes.
- Sits between requester logic and the register storage.
- Provides one combinational read port.

Parameters:
NREQ, 4, number of requesters (2..8)
AW, 3, bank address width; bank depth = 2^AW
DW, 8, data width per entry
MAX_BURST, 8, maximum writes per locked grant (>=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
req  input  NREQ  per-requester write request, level
lock  input  NREQ  per-requester burst hold, sampled only while granted
addr  input  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
wdata  input  NREQ*DW  packed write data, requester i at [i*DW +: DW]
gnt  output  NREQ  registered one-hot grant
ack  output  NREQ  registered one-cycle pulse: write committed
rd_addr  input  AW  read address
rd_data  output  DW  bank[rd_addr], combinational
busy  output  1  high in GRANT state

Behaviour:
- Reset applies on a clk edge with rst=1:
  - state=IDLE, gnt=0, ack=0, ptr=0, burst_cnt=0.
  - All bank entries = 0, so rd_data reads 0.
  - Reset mid-burst aborts it; no write occurs on the reset edge.
- Arbitration: search req from index ptr upward, wrapping modulo NREQ. The first asserted index wins.
- IDLE:
  - gnt=0, busy=0.
  - If any req: gnt <= onehot(winner), burst_cnt <= 0, go to GRANT. Grant is visible the cycle after req is first seen (1-cycle latency).
- GRANT (owner w, busy=1):
  - If req[w]=1:
    - bank[addr_w] <= wdata_w on this edge.
    - ack[w] <= 1 for exactly one cycle.
    - burst_cnt increments.
  - Stay in GRANT if req[w]=1, lock[w]=1 and burst_cnt+1 < MAX_BURST.
  - Otherwise release:
    - ptr <= (w+1) mod NREQ.
    - Re-arbitrate in the same cycle over all req except w, from the new ptr. On a winner, gnt moves directly to it (back-to-back, no idle cycle) and burst_cnt <= 0; if none, gnt <= 0 and go to IDLE.
    - w is excluded only for this re-arbitration; on a later cycle it competes normally.
  - If req[w]=0 while granted: release with no write and no ack.
- A MAX_BURST forced release proceeds even if lock[w]=1. The next winner is picked from w+1, which guarantees fairness.
- ack is never high for two consecutive cycles for the same requester across a release.
- gnt is always one-hot or zero.
- req/lock/addr/wdata of non-granted requesters are ignored.
- Read during write to the same address returns old data; new data is visible the next cycle.
- Address is used as-is; all 2^AW entries are valid, with no out-of-range case.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- When defined:
  - Arbitration is fixed priority: the lowest asserted index wins; ptr is not implemented.
  - After a release, the released owner is still excluded for that one re-arbitration cycle.
  - MAX_BURST still applies.
- When undefined: round-robin as specified above.

Test Plan:
- Reset then idle: rst=1 for 2 cycles. Expect gnt=0, ack=0, busy=0, and rd_data=0 for every rd_addr 0..7.
- Single write: req[2]=1, addr2=5, wdata2=8'hA5 at cycle 0.
  - gnt=4'b0100 at cycle 1; write at end of cycle 1.
  - ack[2]=1 at cycle 2 only; rd_addr=5 reads 8'hA5 from cycle 2.
- Round-robin fairness: req=4'b1111 held, lock=0. Grants rotate 0,1,2,3,0 on consecutive cycles with no idle gaps; each ack follows its grant by one cycle.
- Burst limit: req[1]=1, lock[1]=1 held, req[3]=1.
  - gnt[1] held for exactly 8 writes, then gnt=4'b1000.
  - Addresses 0..7 written with data = address+1 and read back correctly.
- Drop while granted, then reset mid-burst:
  - req[0] drops in its grant cycle: no write, no ack, return to IDLE.
  - rst=1 during a locked burst: gnt=0 and all entries 0 next cycle.
- ARB_FIXED_PRIO_EN build: req=4'b1010 held, lock=0. Expect gnt sequence 0010, 1000, 0010, 1000 (owner exclusion alternates).
